// File: rtl/fir_xifu_mem_req.sv
// rtl/fir_xifu_mem_req.sv - FIR XIFU memory-request issuer: request queue, X-interface mem channel, outstanding tracking
//
// Purpose:
//   Buffers XFIRLW/XFIRSW requests from EX in a small circular FIFO and presents
//   them one at a time on the X-interface memory request channel. Tracks how many
//   accepted requests still await a mem_result, stalls issue at MAX_OUTSTANDING,
//   drops killed head entries before launch, and reports request exceptions.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        EX request handshake (ready = queue not full)
//   req_id_i/we_i/addr_i/wdata_i   request payload
//   kill_i                         per-id kill mask from the controller
//   mem_valid_o/mem_ready_i        memory request handshake towards the core
//   mem_id/addr/we/be/size/mode/wdata_o  request fields (be/size/mode constant)
//   mem_resp_exc_i/exccode_i       exception response, qualified by the handshake
//   mem_result_valid_i             one returned mem_result
//   exc_valid_o/exc_id_o/exc_code_o  one-cycle exception report
//   busy_o                         queue non-empty or requests outstanding

module fir_xifu_mem_req #(
    parameter int X_ID_WIDTH      = 4,
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [X_ID_WIDTH-1:0]      req_id_i,
    input  logic                       req_we_i,
    input  logic [31:0]                req_addr_i,
    input  logic [31:0]                req_wdata_i,
    input  logic [2**X_ID_WIDTH-1:0]   kill_i,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [X_ID_WIDTH-1:0]      mem_id_o,
    output logic [31:0]                mem_addr_o,
    output logic                       mem_we_o,
    output logic [3:0]                 mem_be_o,
    output logic [2:0]                 mem_size_o,
    output logic [1:0]                 mem_mode_o,
    output logic [31:0]                mem_wdata_o,
    input  logic                       mem_resp_exc_i,
    input  logic [5:0]                 mem_resp_exccode_i,
    input  logic                       mem_result_valid_i,
    output logic                       exc_valid_o,
    output logic [X_ID_WIDTH-1:0]      exc_id_o,
    output logic [5:0]                 exc_code_o,
    output logic                       busy_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int EW = X_ID_WIDTH + 1 + 32 + 32;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STALL,
        ST_ISSUE
    } state_e;

    state_e state_q, state_d;

    // launched_q: the head was presented last cycle without being accepted, so
    // it must be held unchanged and kill_i no longer applies to it.
    logic launched_q, launched_d;

    logic [EW-1:0] entry_q [DEPTH];
    logic [EW-1:0] entry_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] out_q, out_d;

    logic                  exc_valid_q, exc_valid_d;
    logic [X_ID_WIDTH-1:0] exc_id_q, exc_id_d;
    logic [5:0]            exc_code_q, exc_code_d;

    logic                  empty, full, push;
    logic                  mem_valid, drop, hs, pop;
    logic                  inc, dec;
    logic [EW-1:0]         head;
    logic [X_ID_WIDTH-1:0] head_id;
    logic                  head_we;
    logic [31:0]           head_addr;
    logic [31:0]           head_wdata;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_C);
    assign push  = req_valid_i & ~full;

    assign head = entry_q[rd_ptr_q];
    assign {head_id, head_we, head_addr, head_wdata} = head;

    // FSM outputs, queue occupancy and outstanding count for the next cycle.
    always_comb begin
        state_d    = state_q;
        launched_d = 1'b0;
        mem_valid  = 1'b0;
        drop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Queue is empty here; a push this cycle is picked up via cnt_d.
            end
            ST_STALL: begin
                if (!empty && kill_i[head_id]) begin
                    drop = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (launched_q) begin
                    mem_valid = 1'b1;
                end else if (!empty) begin
                    if (kill_i[head_id]) begin
                        drop = 1'b1;
                    end else if (out_q < MAX_C) begin
                        mem_valid = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hs  = mem_valid & mem_ready_i;
        pop = hs | drop;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        // A result arriving with nothing outstanding is ignored.
        inc   = hs & ~mem_resp_exc_i;
        dec   = mem_result_valid_i & (out_q != '0);
        out_d = out_q;
        if (inc && !dec) begin
            out_d = out_q + 1'b1;
        end else if (!inc && dec) begin
            out_d = out_q - 1'b1;
        end

        // Deciding from the post-update queue and count lets a push in one
        // cycle present mem_valid_o in the next, and lets a returning result
        // release a stalled head in the cycle after it arrives.
        if (mem_valid && !mem_ready_i) begin
            state_d    = ST_ISSUE;
            launched_d = 1'b1;
        end else if (cnt_d == '0) begin
            state_d = ST_IDLE;
        end else if (out_d >= MAX_C) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_ISSUE;
        end
    end

    // Queue storage, pointers and exception capture.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            entry_d[wr_ptr_q] = {req_id_i, req_we_i, req_addr_i, req_wdata_i};
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        exc_valid_d = hs & mem_resp_exc_i;
        exc_id_d    = exc_id_q;
        exc_code_d  = exc_code_q;
        if (hs && mem_resp_exc_i) begin
            exc_id_d   = head_id;
            exc_code_d = mem_resp_exccode_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            launched_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            exc_valid_q <= 1'b0;
            exc_id_q    <= '0;
            exc_code_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            launched_q  <= launched_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            exc_valid_q <= exc_valid_d;
            exc_id_q    <= exc_id_d;
            exc_code_q  <= exc_code_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign req_ready_o = ~full;
    assign mem_valid_o = mem_valid;
    assign mem_id_o    = head_id;
    assign mem_we_o    = head_we;
    assign mem_addr_o  = head_addr;
    assign mem_wdata_o = head_wdata;
    assign mem_be_o    = 4'b1111;
    assign mem_size_o  = 3'b010;
    assign mem_mode_o  = 2'b11;
    assign exc_valid_o = exc_valid_q;
    assign exc_id_o    = exc_id_q;
    assign exc_code_o  = exc_code_q;
    assign busy_o      = ~empty | (out_q != '0);

endmodule

// File: tb/tb_fir_xifu_mem_req.sv
// tb/tb_fir_xifu_mem_req.sv - scoreboard bench for fir_xifu_mem_req

module tb_fir_xifu_mem_req;

    localparam int XW   = 4;
    localparam int DEP  = 2;
    localparam int MAXO = 2;

    logic          clk, rst_n;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [XW-1:0] req_id_i;
    logic [31:0]   req_addr_i, req_wdata_i;
    logic [15:0]   kill_i;
    logic          mem_valid_o, mem_ready_i, mem_we_o;
    logic [XW-1:0] mem_id_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [2:0]    mem_size_o;
    logic [1:0]    mem_mode_o;
    logic          mem_resp_exc_i;
    logic [5:0]    mem_resp_exccode_i;
    logic          mem_result_valid_i;
    logic          exc_valid_o;
    logic [XW-1:0] exc_id_o;
    logic [5:0]    exc_code_o;
    logic          busy_o;

    fir_xifu_mem_req #(.X_ID_WIDTH(XW), .DEPTH(DEP), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_id_i(req_id_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .kill_i(kill_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_id_o(mem_id_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_size_o(mem_size_o), .mem_mode_o(mem_mode_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_resp_exc_i(mem_resp_exc_i), .mem_resp_exccode_i(mem_resp_exccode_i),
        .mem_result_valid_i(mem_result_valid_i),
        .exc_valid_o(exc_valid_o), .exc_id_o(exc_id_o), .exc_code_o(exc_code_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_pass = 0;
    int           n_total = 0;
    int           model_out = 0;
    bit           mon_en = 0;
    bit           held = 0;
    logic [68:0]  held_fields;
    logic [68:0]  exp_q [$];
    logic [9:0]   exc_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples mid-cycle, retires expected requests on each handshake
    // and keeps the reference count of outstanding requests.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [68:0] cur;
            logic [9:0]  e;
            int          old_out;
            cur = {mem_id_o, mem_we_o, mem_addr_o, mem_wdata_o};
            if (exc_valid_o) begin
                if (exc_q.size() == 0) begin
                    n_total++;
                    $display("FAIL exc_unexpected: got id=%0d code=%0d expected no pulse", exc_id_o, exc_code_o);
                end else begin
                    e = exc_q.pop_front();
                    check("exc_pulse", {exc_id_o, exc_code_o}, e);
                end
            end else if (exc_q.size() != 0) begin
                n_total++;
                $display("FAIL exc_missing: got no pulse expected %0h", exc_q[0]);
                exc_q.delete();
            end
            if (held) check("launch_hold", {mem_valid_o, cur}, {1'b1, held_fields});
            if (mem_valid_o) check("out_limit", model_out < MAXO, 1'b1);
            old_out = model_out;
            if (mem_valid_o && mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL mem_req_unexpected: got id=%0d addr=%0h expected none", mem_id_o, mem_addr_o);
                end else begin
                    check("mem_req", {cur, mem_be_o, mem_size_o, mem_mode_o},
                          {exp_q.pop_front(), 4'hF, 3'b010, 2'b11});
                end
                if (mem_resp_exc_i) exc_q.push_back({mem_id_o, mem_resp_exccode_i});
                else model_out++;
            end
            if (mem_result_valid_i && old_out > 0) model_out--;
            held = mem_valid_o && !mem_ready_i;
            held_fields = cur;
        end
    end

    task automatic push_req(input logic [3:0] id, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit expect_issue);
        bit ok;
        ok = 0;
        req_valid_i = 1'b1; req_id_i = id; req_we_i = we;
        req_addr_i = addr; req_wdata_i = wdata;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready_o;
            tick();
        end
        req_valid_i = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL push_timeout: got ready=0 for id=%0d expected acceptance", id);
        end else if (expect_issue) begin
            exp_q.push_back({id, we, addr, wdata});
        end
    endtask

    task automatic drain;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && model_out == 0) break;
            mem_result_valid_i = (model_out > 0);
            tick();
        end
        mem_result_valid_i = 1'b0;
        check("drain_done", exp_q.size() + model_out, 0);
        @(negedge clk);
        check("drain_idle", busy_o, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        rst_n = 1'b0; req_valid_i = 0; req_id_i = 0; req_we_i = 0; req_addr_i = 0;
        req_wdata_i = 0; kill_i = 0; mem_ready_i = 0; mem_resp_exc_i = 0;
        mem_resp_exccode_i = 0; mem_result_valid_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_valid_o, req_ready_o, exc_valid_o, busy_o}, 4'b0100);
        check("reset_fields", {mem_id_o, mem_we_o, mem_addr_o, mem_wdata_o, exc_id_o, exc_code_o}, 0);
        tick();
        rst_n = 1'b1;
        mon_en = 1;

        // Single load: one-cycle latency, busy until result returns.
        mem_ready_i = 1'b1;
        req_valid_i = 1'b1; req_id_i = 4'd3; req_we_i = 1'b0;
        req_addr_i = 32'h1000_0040; req_wdata_i = $urandom;
        exp_q.push_back({4'd3, 1'b0, 32'h1000_0040, req_wdata_i});
        @(negedge clk);
        check("t1_not_same_cycle", mem_valid_o, 1'b0);
        tick();
        req_valid_i = 1'b0;
        @(negedge clk);
        check("t1_valid_next", {mem_valid_o, mem_id_o, mem_addr_o, mem_be_o}, {1'b1, 4'd3, 32'h1000_0040, 4'hF});
        tick();
        @(negedge clk);
        check("t1_busy_outstanding", busy_o, 1'b1);
        tick();
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t1_busy_clear", busy_o, 1'b0);
        tick();

        // Backpressure: launched store held while kill for its id pulses.
        mem_ready_i = 1'b0;
        push_req(4'd5, 1'b1, $urandom, 32'hDEAD_BEEF, 1);
        for (int i = 0; i < 4; i++) begin
            kill_i = (i % 2 == 1) ? 16'h0020 : 16'h0000;
            @(negedge clk);
            check("t2_hold_valid", mem_valid_o, 1'b1);
            tick();
        end
        kill_i = 0;
        mem_ready_i = 1'b1;
        tick();
        @(negedge clk);
        check("t2_single_hs", mem_valid_o, 1'b0);
        tick();
        drain();

        // Pre-launch kill while stalled at the outstanding limit; full queue.
        push_req(4'd8, 1'b0, $urandom, $urandom, 1);
        push_req(4'd9, 1'b1, $urandom, $urandom, 1);
        push_req(4'd1, 1'b0, $urandom, $urandom, 0);
        push_req(4'd2, 1'b1, $urandom, $urandom, 1);
        req_valid_i = 1'b1; req_id_i = 4'd10;
        @(negedge clk);
        check("t3_full_ready", req_ready_o, 1'b0);
        check("t3_stall", mem_valid_o, 1'b0);
        tick();
        req_valid_i = 1'b0;
        kill_i = 16'h0002;
        tick();
        kill_i = 0;
        @(negedge clk);
        check("t3_drop_frees_slot", {mem_valid_o, req_ready_o}, 2'b01);
        tick();
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t3_issue_id2", {mem_valid_o, mem_id_o}, {1'b1, 4'd2});
        tick();
        drain();

        // Outstanding limit: third request waits for a result.
        push_req(4'd11, 1'b0, $urandom, $urandom, 1);
        push_req(4'd12, 1'b0, $urandom, $urandom, 1);
        push_req(4'd13, 1'b1, $urandom, $urandom, 1);
        @(negedge clk);
        check("t4_stall_a", mem_valid_o, 1'b0);
        tick();
        @(negedge clk);
        check("t4_stall_b", mem_valid_o, 1'b0);
        tick();
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t4_release", {mem_valid_o, mem_id_o}, {1'b1, 4'd13});
        tick();
        drain();

        // Exception on handshake.
        push_req(4'd7, 1'b0, $urandom, $urandom, 1);
        mem_resp_exc_i = 1'b1; mem_resp_exccode_i = 6'd5;
        tick();
        mem_resp_exc_i = 1'b0; mem_resp_exccode_i = 6'd0;
        @(negedge clk);
        check("t5_exc_fields", {exc_valid_o, exc_id_o, exc_code_o}, {1'b1, 4'd7, 6'd5});
        check("t5_count_unchanged", busy_o, 1'b0);
        tick();
        @(negedge clk);
        check("t5_one_cycle", exc_valid_o, 1'b0);
        tick();

        // Result at zero is ignored; handshake and result together cancel.
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t6_no_underflow", busy_o, 1'b0);
        tick();
        push_req(4'd4, 1'b0, $urandom, $urandom, 1);
        tick();
        push_req(4'd6, 1'b1, $urandom, $urandom, 1);
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t6_simul_unchanged", busy_o, 1'b1);
        tick();
        mem_result_valid_i = 1'b1;
        tick();
        mem_result_valid_i = 1'b0;
        @(negedge clk);
        check("t6_final_zero", busy_o, 1'b0);
        tick();

        // Randomized traffic; ids 14 and 15 are killed throughout.
        kill_i = 16'hC000;
        for (int c = 0; c < 400; c++) begin
            req_valid_i = ($urandom % 4) != 0;
            req_id_i = 4'($urandom_range(0, 15));
            req_we_i = 1'($urandom);
            req_addr_i = $urandom;
            req_wdata_i = $urandom;
            mem_ready_i = ($urandom % 4) != 0;
            mem_result_valid_i = (model_out > 0) ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
            mem_resp_exc_i = ($urandom % 6) == 0;
            mem_resp_exccode_i = 6'($urandom);
            @(negedge clk);
            acc = req_valid_i && req_ready_o;
            if (acc && !kill_i[req_id_i]) exp_q.push_back({req_id_i, req_we_i, req_addr_i, req_wdata_i});
            tick();
        end
        req_valid_i = 1'b0; mem_resp_exc_i = 1'b0;
        drain();
        kill_i = 0;

        // Asynchronous reset clears a launched request at once.
        mem_ready_i = 1'b0;
        push_req(4'd9, 1'b0, $urandom, $urandom, 0);
        mon_en = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {mem_valid_o, busy_o, req_ready_o}, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
